// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard scoreboard, stall generation and jump flush/redirect sequencing.
// Optional: define WB_BYPASS_EN so that a source retiring this cycle does not stall decode.
module pipeline_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_rd_we,
    input  logic                  ex_flush_req,
    input  logic [ADDR_W-1:0]     ex_flush_addr,
    input  logic                  mem_busy,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_we,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  stall_execute,
    output logic                  flush_fetch,
    output logic                  flush_decode,
    output logic                  redirect_valid,
    output logic [ADDR_W-1:0]     redirect_addr,
    output logic [NUM_REGS-1:0]   busy_mask
);
    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t              state;
    logic [CW-1:0]       drain_cnt;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] hz_mask;
    logic                hazard;
    logic                issue;

    // Hazard detection, stall fan-out and scoreboard update vectors
    always_comb begin
        clr_vec = (wb_valid && wb_we && wb_rd != '0) ? (NUM_REGS'(1) << wb_rd) : '0;
`ifdef WB_BYPASS_EN
        hz_mask = busy_mask & ~clr_vec;
`else
        hz_mask = busy_mask;
`endif
        hazard = dec_valid & ((dec_rs1_used & hz_mask[dec_rs1]) | (dec_rs2_used & hz_mask[dec_rs2]));
        stall_decode = hazard | mem_busy;
        stall_fetch = stall_decode;
        stall_execute = mem_busy;
        issue = dec_valid & ~stall_decode & ~ex_flush_req & (state == IDLE);
        set_vec = (issue && dec_rd_we && dec_rd != '0) ? (NUM_REGS'(1) << dec_rd) : '0;
    end

    // Scoreboard: a younger writer setting a bit beats a same-cycle retirement clearing it
    always_ff @(posedge clk) begin
        if (reset)
            busy_mask <= '0;
        else
            busy_mask <= (busy_mask & ~clr_vec) | set_vec;
    end

    // Flush sequencer: latch target, pulse redirect/flush for one cycle, then hold issue while fetch refills
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
            flush_fetch    <= 1'b0;
            flush_decode   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_flush_req && !mem_busy) begin
                        state          <= REDIRECT;
                        redirect_addr  <= ex_flush_addr;
                        redirect_valid <= 1'b1;
                        flush_fetch    <= 1'b1;
                        flush_decode   <= 1'b1;
                    end
                end
                REDIRECT: begin
                    state          <= DRAIN;
                    drain_cnt      <= CW'(DRAIN_CYCLES);
                    redirect_valid <= 1'b0;
                    flush_fetch    <= 1'b0;
                    flush_decode   <= 1'b0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CW'(1);
                    if (drain_cnt == CW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
